// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
//   op_e        : operation select (OP_ADD / OP_SUB)
//   chunk_width : width of one carry chunk for a given WIDTH/STAGES split
//   sat_max/min : signed saturation bounds, LSB-aligned in a MaxWidth vector
package add_sub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Upper bound on supported operand width for the saturation helpers.
  localparam int unsigned MaxWidth = 1024;

  function automatic int unsigned chunk_width(int unsigned width, int unsigned stages);
    return width / stages;
  endfunction

  function automatic logic [MaxWidth-1:0] sat_max(int unsigned width);
    logic [MaxWidth-1:0] one;
    one = 1;
    return (one << (width - 1)) - one;
  endfunction

  function automatic logic [MaxWidth-1:0] sat_min(int unsigned width);
    logic [MaxWidth-1:0] one;
    one = 1;
    return one << (width - 1);
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// One registered slice of the carry chain.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   en              : pipeline advance enable; registers hold when low
//   a, b, cin       : chunk operands (b already inverted for subtract) and carry-in
//   s, cout         : registered chunk sum and carry-out
//   msb_carry       : registered carry into the chunk MSB; xor with cout gives signed overflow
module add_sub_chunk
  import add_sub_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             msb_carry
);

  logic [CHUNK:0] total;
  logic           msb_c;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  // Recover the carry into the top bit from its sum bit.
  assign msb_c = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s         <= '0;
      cout      <= 1'b0;
      msb_carry <= 1'b0;
    end else if (en) begin
      s         <= total[CHUNK-1:0];
      cout      <= total[CHUNK];
      msb_carry <= msb_c;
    end
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor; the carry chain is cut into STAGES chunks,
// one chunk resolved per cycle. Latency is STAGES cycles, one beat per cycle.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid/in_ready       : operand handshake (a, b, cin, op)
//   op                      : 0 = a + b + cin, 1 = a - b - cin
//   out_valid/out_ready     : result handshake (sum, cout, ovf, zero)
//   cout                    : carry-out; for subtract 1 means no borrow
//   ovf                     : signed overflow
//   zero                    : result is zero (valid only with out_valid)
// Build option: define ADD_SUB_SATURATE_EN to clamp overflowing results to the
// signed max/min; otherwise results wrap.
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] ChunkMask = WIDTH'({CHUNK{1'b1}});

  if (STAGES == 0 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             en;
  op_e              op_sel;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Slot k = state after stage k. a_q/b_q are the skew registers (chunks above k
  // still pending); res_q holds the already-resolved lower chunks (deskew).
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  a_q      [STAGES];
  logic [WIDTH-1:0]  b_q      [STAGES];
  logic [WIDTH-1:0]  res_q    [STAGES];
  logic [WIDTH-1:0]  res_full [STAGES];
  logic [CHUNK-1:0]  s_c      [STAGES];
  logic              co_c     [STAGES];
  logic              mc_c     [STAGES];

  logic [WIDTH-1:0] sum_raw;

  // Everything advances together; a stalled output freezes the whole pipe.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign op_sel  = op_e'(op);
  assign b_eff   = (op_sel == OP_SUB) ? ~b : b;
  assign cin_eff = (op_sel == OP_SUB) ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic             c_in;

    if (k == 0) begin : g_first
      assign op_a = a[CHUNK-1:0];
      assign op_b = b_eff[CHUNK-1:0];
      assign c_in = cin_eff;
    end else begin : g_next
      assign op_a = a_q[k-1][k*CHUNK +: CHUNK];
      assign op_b = b_q[k-1][k*CHUNK +: CHUNK];
      assign c_in = co_c[k-1];
    end

    add_sub_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .a        (op_a),
      .b        (op_b),
      .cin      (c_in),
      .s        (s_c[k]),
      .cout     (co_c[k]),
      .msb_carry(mc_c[k])
    );

    // Lower chunks of slot k merged with the chunk this stage just produced.
    assign res_full[k] = (res_q[k] & ~(ChunkMask << (k * CHUNK)))
                       | (WIDTH'(s_c[k]) << (k * CHUNK));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else if (en) begin
      valid_q[0] <= in_valid;
      a_q[0]     <= a;
      b_q[0]     <= b_eff;
      res_q[0]   <= '0;
      for (int i = 1; i < int'(STAGES); i++) begin
        valid_q[i] <= valid_q[i-1];
        a_q[i]     <= a_q[i-1];
        b_q[i]     <= b_q[i-1];
        res_q[i]   <= res_full[i-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum_raw   = res_full[STAGES-1];
  assign cout      = co_c[STAGES-1];
  assign ovf       = co_c[STAGES-1] ^ mc_c[STAGES-1];

`ifdef ADD_SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SatMin = WIDTH'(sat_min(WIDTH));
  // On overflow the wrapped MSB is the inverse of a's MSB, so it picks the clamp.
  assign sum = ovf ? (sum_raw[WIDTH-1] ? SatMax : SatMin) : sum_raw;
`else
  assign sum = sum_raw;
`endif

  assign zero = out_valid && (sum == '0);

endmodule

// File: tb/tb_pipelined_add_sub.sv
module tb_pipelined_add_sub;

  localparam int NDUT = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [NDUT];
  logic        in_ready  [NDUT];
  logic [31:0] a         [NDUT];
  logic [31:0] b         [NDUT];
  logic        cin       [NDUT];
  logic        op        [NDUT];
  logic        out_valid [NDUT];
  logic        out_ready [NDUT];
  logic [31:0] sum       [NDUT];
  logic        cout      [NDUT];
  logic        ovf       [NDUT];
  logic        zero      [NDUT];

  int checks;
  int failures;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pipelined_add_sub #(
      .WIDTH (32),
      .STAGES(g == 0 ? 4 : (g == 1 ? 1 : 32))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .a        (a[g]),
      .b        (b[g]),
      .cin      (cin[g]),
      .op       (op[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .sum      (sum[g]),
      .cout     (cout[g]),
      .ovf      (ovf[g]),
      .zero     (zero[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        op;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  vec_t vecs [10];

  function automatic int stages_of(int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 32);
  endfunction

  function automatic res_t model(logic [31:0] x, logic [31:0] y, logic c, logic o);
    logic [31:0] yy;
    logic        cc;
    logic [32:0] t;
    res_t        r;
    yy     = o ? ~y : y;
    cc     = o ? ~c : c;
    t      = {1'b0, x} + {1'b0, yy} + {32'b0, cc};
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (x[31] == yy[31]) && (t[31] != x[31]);
`ifdef ADD_SUB_SATURATE_EN
    if (r.ovf) r.sum = x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
`endif
    r.zero = (r.sum == 32'h0);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(int i, logic [31:0] va, logic [31:0] vb, logic vc, logic vo,
                         logic [31:0] vs, logic vco, logic vov, logic vz);
    vecs[i].a    = va;
    vecs[i].b    = vb;
    vecs[i].cin  = vc;
    vecs[i].op   = vo;
    vecs[i].sum  = vs;
    vecs[i].cout = vco;
    vecs[i].ovf  = vov;
    vecs[i].zero = vz;
  endtask

  // Single beat into an idle DUT; checks latency and all result fields.
  task automatic run_vec(int d, int i);
    string tag;
    int    lat;
    tag         = $sformatf("v%0d_s%0d", i, stages_of(d));
    a[d]        = vecs[i].a;
    b[d]        = vecs[i].b;
    cin[d]      = vecs[i].cin;
    op[d]       = vecs[i].op;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready[d]), 32'd1);
    tick();
    in_valid[d] = 1'b0;
    lat = 1;
    while (!out_valid[d] && lat < 80) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(stages_of(d)));
    check({tag, "_sum"}, sum[d], vecs[i].sum);
    check({tag, "_cout"}, 32'(cout[d]), 32'(vecs[i].cout));
    check({tag, "_ovf"}, 32'(ovf[d]), 32'(vecs[i].ovf));
    check({tag, "_zero"}, 32'(zero[d]), 32'(vecs[i].zero));
    tick();
  endtask

  // 8 back-to-back beats, output stalled 3 cycles after the 2nd result.
  task automatic run_bp(int d);
    logic [31:0] ba [8];
    logic [31:0] bb [8];
    logic        bc [8];
    logic        bo [8];
    res_t        q [$];
    res_t        e;
    int          sent, recv, stall, cyc, t_first, t_last, extra, s;
    logic [31:0] snap_sum;
    logic [2:0]  snap_flags;
    bit          have_snap;
    string       tag;
    tag = $sformatf("bp_s%0d", stages_of(d));
    s = stages_of(d);
    for (int j = 0; j < 8; j++) begin
      ba[j] = $urandom();
      bb[j] = $urandom();
      bc[j] = 1'($urandom_range(0, 1));
      bo[j] = 1'($urandom_range(0, 1));
    end
    sent = 0; recv = 0; stall = 0; cyc = 0; t_first = -1; t_last = -1; have_snap = 0;
    while (recv < 8 && cyc < 300) begin
      out_ready[d] = !(recv == 2 && stall < 3);
      if (!out_ready[d]) stall++;
      #1;
      if (out_valid[d] && !out_ready[d]) begin
        check({tag, "_stall_in_ready"}, 32'(in_ready[d]), 32'd0);
        if (have_snap) begin
          check({tag, "_hold_sum"}, sum[d], snap_sum);
          check({tag, "_hold_flags"}, 32'({cout[d], ovf[d], zero[d]}), 32'(snap_flags));
        end else begin
          snap_sum   = sum[d];
          snap_flags = {cout[d], ovf[d], zero[d]};
          have_snap  = 1;
        end
      end
      if (out_valid[d] && out_ready[d]) begin
        if (q.size() == 0) begin
          check({tag, "_unexpected_result"}, 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check($sformatf("%s_r%0d_sum", tag, recv), sum[d], e.sum);
          check($sformatf("%s_r%0d_flags", tag, recv), 32'({cout[d], ovf[d], zero[d]}),
                32'({e.cout, e.ovf, e.zero}));
        end
        recv++;
        t_last = cyc;
      end
      if (sent < 8) begin
        a[d] = ba[sent]; b[d] = bb[sent]; cin[d] = bc[sent]; op[d] = bo[sent];
        in_valid[d] = 1'b1;
        if (in_ready[d]) begin
          q.push_back(model(ba[sent], bb[sent], bc[sent], bo[sent]));
          if (sent == 0) t_first = cyc;
          sent++;
        end
      end else begin
        in_valid[d] = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    check({tag, "_count"}, 32'(recv), 32'd8);
    check({tag, "_throughput"}, 32'(t_last - t_first), 32'(s + 10));
    extra = 0;
    for (int j = 0; j < s + 4; j++) begin
      if (out_valid[d]) extra++;
      tick();
    end
    check({tag, "_no_duplicates"}, 32'(extra), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int seen;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1;
      a[d] = '0; b[d] = '0; cin[d] = 1'b0; op[d] = 1'b0;
    end

    //        a             b             cin   op    sum           cout  ovf   zero
    set_vec(0, 32'h0000_00ff, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    set_vec(1, 32'hffff_ffff, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    set_vec(2, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hffff_fffe, 1'b0, 1'b0, 1'b0);
    set_vec(3, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    set_vec(6, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    set_vec(8, 32'h1234_5678, 32'h9abc_def0, 1'b1, 1'b0, 32'hacf1_3569, 1'b0, 1'b0, 1'b0);
    set_vec(9, 32'h0000_ffff, 32'hffff_0000, 1'b1, 1'b1, 32'h0001_fffe, 1'b0, 1'b0, 1'b0);
`ifdef ADD_SUB_SATURATE_EN
    set_vec(4, 32'h7fff_ffff, 32'h0000_0001, 1'b0, 1'b0, 32'h7fff_ffff, 1'b0, 1'b1, 1'b0);
    set_vec(5, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    set_vec(7, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
    set_vec(4, 32'h7fff_ffff, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    set_vec(5, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7fff_ffff, 1'b1, 1'b1, 1'b0);
    set_vec(7, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
`endif

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_s%0d_out_valid", stages_of(d)), 32'(out_valid[d]), 32'd0);
      check($sformatf("rst_s%0d_in_ready", stages_of(d)), 32'(in_ready[d]), 32'd1);
      check($sformatf("rst_s%0d_sum", stages_of(d)), sum[d], 32'd0);
      check($sformatf("rst_s%0d_flags", stages_of(d)),
            32'({cout[d], ovf[d], zero[d]}), 32'd0);
    end

    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 10; i++) run_vec(d, i);
    end

    for (int d = 0; d < NDUT; d++) run_bp(d);

    // Reset with three beats in flight on the 4-stage DUT.
    out_ready[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a[0] = vecs[j + 7].a; b[0] = vecs[j + 7].b;
      cin[0] = vecs[j + 7].cin; op[0] = vecs[j + 7].op;
      in_valid[0] = 1'b1;
      tick();
    end
    in_valid[0] = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_sum", sum[0], 32'd0);
    check("midrst_flags", 32'({cout[0], ovf[0], zero[0]}), 32'd0);
    check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    seen = 0;
    for (int j = 0; j < 10; j++) begin
      if (out_valid[0]) seen++;
      tick();
    end
    check("midrst_no_stale", 32'(seen), 32'd0);
    run_vec(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
